// File: rtl/serial_adder_fsm.sv
// -----------------------------------------------------------------------------
// serial_adder_fsm
//
// Bit-serial unsigned adder. Two WIDTH-bit operands are captured on an accepted
// start and added LSB-first, one bit per clock. Each bit is formed by two
// cascaded half-adder cells feeding a registered carry flop. The finished sum
// and carry-out are registered and held until the next operation completes.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      operation request, sampled only while idle
//   a      in   WIDTH  operand A, captured on the accepted start edge
//   b      in   WIDTH  operand B, captured on the accepted start edge
//   busy   out  1      high while bits are being shifted through the adder
//   done   out  1      one-cycle pulse; s/c are valid from this cycle onward
//   s      out  WIDTH  registered sum, (a+b) mod 2^WIDTH
//   c      out  1      registered carry-out, bit WIDTH of a+b
// -----------------------------------------------------------------------------
module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               cy_q, cy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               c_q, c_d;

    // Two cascaded half-adder cells: the first combines the operand bits, the
    // second folds in the stored carry. Either cell's carry produces carry-out.
    logic ha1_sum, ha1_cy, ha2_sum, ha2_cy;
    logic sum_bit, cy_next;

    always_comb begin
        ha1_sum = opa_q[0] ^ opb_q[0];
        ha1_cy  = opa_q[0] & opb_q[0];
        ha2_sum = ha1_sum ^ cy_q;
        ha2_cy  = ha1_sum & cy_q;
        sum_bit = ha2_sum;
        cy_next = ha1_cy | ha2_cy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        c_d     = c_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    cy_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Result fills from the top so the first (LSB) bit ends up at
                // bit 0 after WIDTH shifts.
                res_d = {sum_bit, res_q[WIDTH-1:1]};
                opa_d = {1'b0, opa_q[WIDTH-1:1]};
                opb_d = {1'b0, opb_q[WIDTH-1:1]};
                cy_d  = cy_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Publish including the bit being produced on this edge.
                    s_d     = {sum_bit, res_q[WIDTH-1:1]};
                    c_d     = cy_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs decode the state register only, so start/a/b never reach
    // an output combinationally.
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign c    = c_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
module tb_serial_adder_fsm;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c;

    serial_adder_fsm #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: edges elapsed since the accepted start (-1 = idle and
    // ready), the pending exact sum, and the published {c,s}.
    int             since    = -1;
    logic [WIDTH:0] pending  = '0;
    logic [WIDTH:0] exp_res  = '0;
    int             done_seen = 0;
    int             busy_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock, update the model from the inputs seen at that edge,
    // then compare all outputs just after the edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) begin
            since   = -1;
            pending = '0;
            exp_res = '0;
        end else if (since < 0) begin
            if (start) begin
                since   = 0;
                pending = {1'b0, a} + {1'b0, b};
            end
        end else begin
            since++;
            if (since == WIDTH) exp_res = pending;
            if (since == WIDTH + 1) since = -1;
        end
        #1;
        chk("busy", busy, (since >= 0 && since < WIDTH));
        chk("done", done, (since == WIDTH));
        chk("s", s, exp_res[WIDTH-1:0]);
        chk("c", c, exp_res[WIDTH]);
        if (done) done_seen++;
        if (busy) busy_seen++;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic [WIDTH-1:0] want_s, input logic want_c);
        a = xa;
        b = xb;
        start = 1'b1;
        done_seen = 0;
        busy_seen = 0;
        cycle();
        start = 1'b0;
        repeat (WIDTH + 1) cycle();
        chk("op_s", s, want_s);
        chk("op_c", c, want_c);
        chk("op_busy_len", busy_seen, WIDTH);
        chk("op_done_cnt", done_seen, 1);
    endtask

    initial begin
        int dt[$];
        rst_n = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s", s, 0);
        chk("rst_c", c, 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();

        run_op(8'd3, 8'd5, 8'd8, 1'b0);
        run_op(8'd255, 8'd1, 8'd0, 1'b1);
        run_op(8'd255, 8'd255, 8'd254, 1'b1);
        run_op(8'd0, 8'd0, 8'd0, 1'b0);

        // Held start: back-to-back operations; operands disturbed mid-flight.
        a = 8'd10;
        b = 8'd20;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (i == 3) begin a = 8'd1; b = 8'd1; end
            if (i == 6) begin a = 8'd10; b = 8'd20; end
            if (done) begin
                dt.push_back(i);
                chk("held_s", s, 30);
                chk("held_c", c, 0);
            end
        end
        start = 1'b0;
        chk("held_ndone_ge2", (dt.size() >= 2), 1);
        if (dt.size() >= 2) chk("held_gap", dt[1] - dt[0], 10);
        repeat (WIDTH + 3) cycle();

        // Start pulse while busy must be ignored.
        done_seen = 0;
        a = 8'd50;
        b = 8'd60;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        a = 8'd7;
        b = 8'd9;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (2 * WIDTH) cycle();
        chk("busy_start_done_cnt", done_seen, 1);
        chk("busy_start_s", s, 110);

        // Asynchronous reset in the middle of an operation.
        a = 8'd200;
        b = 8'd100;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_s", s, 0);
        chk("midrst_c", c, 0);
        cycle();
        rst_n = 1'b1;
        done_seen = 0;
        repeat (WIDTH + 4) cycle();
        chk("midrst_no_done", done_seen, 0);
        run_op(8'd100, 8'd27, 8'd127, 1'b0);

        // Randomized traffic against the model, with one reset mid-stream.
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 2) == 0);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            rst_n = (i != 200);
            cycle();
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (WIDTH + 3) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
